param_reg_file: RTL and testbench

PARAM_REG_FILE -- requirements
Module: param_reg_file

---
 rtl/param_reg_file_pkg.sv | 12 +
 rtl/param_reg_file_if.sv | 29 ++
 rtl/reg_sweep_ctrl.sv | 58 +++++
 rtl/param_reg_file.sv | 73 +++++++
 tb/tb_param_reg_file.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/param_reg_file_pkg.sv
// Shared types and default sizes for the parameterised register file.
package param_reg_file_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultDepth = 32;

  typedef enum logic {
    StSweep,
    StRun
  } state_e;

endpackage

// File: rtl/param_reg_file_if.sv
// Write/read port bundle of the register file; master drives requests, slave returns data.
interface param_reg_file_if
  import param_reg_file_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned ADDR_W = $clog2(DefaultDepth)
);

  logic              Clear;
  logic              RegWrite;
  logic [ADDR_W-1:0] WriteRegister;
  logic [WIDTH-1:0]  WriteData;
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [WIDTH-1:0]  ReadData1;
  logic [WIDTH-1:0]  ReadData2;
  logic              Ready;

  modport master (
    output Clear, RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    input  ReadData1, ReadData2, Ready
  );

  modport slave (
    input  Clear, RegWrite, WriteRegister, WriteData, ReadRegister1, ReadRegister2,
    output ReadData1, ReadData2, Ready
  );

endinterface

// File: rtl/reg_sweep_ctrl.sv
// Zeroing-sweep controller: walks every register index once after reset or Clear.
module reg_sweep_ctrl
  import param_reg_file_pkg::*;
#(
  parameter int unsigned DEPTH  = DefaultDepth,
  parameter int unsigned ADDR_W = $clog2(DefaultDepth)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  output logic              ready,
  output logic              sweep_we,
  output logic [ADDR_W-1:0] sweep_addr
);

  localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StSweep;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sweep_we = 1'b0;
    unique case (state_q)
      StSweep: begin
        sweep_we = 1'b1;
        if (idx_q == LastIdx) begin
          state_d = StRun;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + ADDR_W'(1);
        end
      end
      StRun: begin
        if (clear) begin
          state_d = StSweep;
          idx_d   = '0;
        end
      end
      default: state_d = StSweep;
    endcase
  end

  assign ready      = (state_q == StRun);
  assign sweep_addr = idx_q;

endmodule

// File: rtl/param_reg_file.sv
// Register file with optional hardwired zero register, write-to-read bypass and sweep-clear.
module param_reg_file
  import param_reg_file_pkg::*;
#(
  parameter int unsigned WIDTH    = DefaultWidth,
  parameter int unsigned DEPTH    = DefaultDepth,
  parameter int unsigned ZERO_REG = 1,
  parameter int unsigned BYPASS   = 1
) (
  input logic             clk,
  input logic             reset,
  param_reg_file_if.slave bus
);

  localparam int unsigned       ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DepthW = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0]  regs_q [DEPTH];
  logic              ready;
  logic              sweep_we;
  logic [ADDR_W-1:0] sweep_addr;
  logic              wr_legal;

  reg_sweep_ctrl #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_sweep (
    .clk        (clk),
    .reset      (reset),
    .clear      (bus.Clear),
    .ready      (ready),
    .sweep_we   (sweep_we),
    .sweep_addr (sweep_addr)
  );

  function automatic logic addr_writable(input logic [ADDR_W-1:0] addr);
    return ({1'b0, addr} < DepthW) && !((ZERO_REG != 0) && (addr == '0));
  endfunction

  // Clear in the same cycle as a write wins: the write is dropped.
  assign wr_legal = ready && bus.RegWrite && !bus.Clear && addr_writable(bus.WriteRegister);

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (sweep_we) begin
        regs_q[sweep_addr] <= '0;
      end else if (wr_legal) begin
        regs_q[bus.WriteRegister] <= bus.WriteData;
      end
    end
  end

  function automatic logic [WIDTH-1:0] read_port(input logic [ADDR_W-1:0] addr);
    logic [WIDTH-1:0] data;
    data = '0;
    if (ready && addr_writable(addr)) begin
      if ((BYPASS != 0) && wr_legal && (bus.WriteRegister == addr)) begin
        data = bus.WriteData;
      end else begin
        data = regs_q[addr];
      end
    end
    return data;
  endfunction

  always_comb begin
    bus.ReadData1 = read_port(bus.ReadRegister1);
    bus.ReadData2 = read_port(bus.ReadRegister2);
  end

  assign bus.Ready = ready;

endmodule

// File: tb/tb_param_reg_file.sv
// Directed bench: three register-file configurations checked through a cycle-tagged scoreboard.
module tb_param_reg_file;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  param_reg_file_if #(.WIDTH(32), .ADDR_W(5)) bus_a ();
  param_reg_file_if #(.WIDTH(32), .ADDR_W(5)) bus_b ();
  param_reg_file_if #(.WIDTH(8),  .ADDR_W(4)) bus_c ();

  param_reg_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut_a (
    .clk(clk), .reset(reset), .bus(bus_a)
  );
  param_reg_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(0)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b)
  );
  param_reg_file #(.WIDTH(8), .DEPTH(12), .ZERO_REG(1), .BYPASS(1)) dut_c (
    .clk(clk), .reset(reset), .bus(bus_c)
  );

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  logic [31:0] actual;

  localparam int ARd1 = 0, ARd2 = 1, ARdy = 2, BRd1 = 3, BRdy = 4, CRd1 = 5, CRd2 = 6, CRdy = 7;

  function automatic logic [31:0] sample(input int sel);
    case (sel)
      ARd1:    return bus_a.ReadData1;
      ARd2:    return bus_a.ReadData2;
      ARdy:    return 32'(bus_a.Ready);
      BRd1:    return bus_b.ReadData1;
      BRdy:    return 32'(bus_b.Ready);
      CRd1:    return 32'(bus_c.ReadData1);
      CRd2:    return 32'(bus_c.ReadData2);
      CRdy:    return 32'(bus_c.Ready);
      default: return 'x;
    endcase
  endfunction

  // Monitor: compares every expectation tagged for the current cycle, mid-cycle.
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      actual = sample(e.sel);
      checks++;
      if (e.cyc != cyc || actual !== e.val) begin
        errors++;
        $display("FAIL %s: cycle %0d got %h want %h", e.name, e.cyc, actual, e.val);
      end
    end
  end

  task automatic chk(input int sel, input logic [31:0] v, input string name);
    exp_q.push_back('{cyc, sel, v, name});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus_a.Clear = 0; bus_a.RegWrite = 0; bus_a.WriteRegister = '0; bus_a.WriteData = '0;
    bus_a.ReadRegister1 = 5'd3; bus_a.ReadRegister2 = '0;
    bus_b.Clear = 0; bus_b.RegWrite = 0; bus_b.WriteRegister = '0; bus_b.WriteData = '0;
    bus_b.ReadRegister1 = '0; bus_b.ReadRegister2 = '0;
    bus_c.Clear = 0; bus_c.RegWrite = 0; bus_c.WriteRegister = '0; bus_c.WriteData = '0;
    bus_c.ReadRegister1 = '0; bus_c.ReadRegister2 = '0;

    step(); step(); step();
    chk(ARdy, 0, "reset_ready");
    chk(ARd1, 0, "reset_rd1_zero");
    reset = 1'b0;

    // First sweep, interrupted by reset at sweep cycle 10.
    for (int i = 0; i < 10; i++) begin
      if (i == 0 || i == 9) chk(ARdy, 0, "sweep1_ready_low");
      step();
    end
    reset = 1'b1;
    chk(ARdy, 0, "midsweep_reset_ready");
    step();
    reset = 1'b0;

    for (int i = 0; i <= 32; i++) begin
      if (i == 0)  chk(ARd1, 0, "sweep_rd_forced_zero");
      if (i == 0 || i == 31) chk(ARdy, 0, "sweep2_ready_low");
      if (i == 11) chk(CRdy, 0, "c_ready_low_11");
      if (i == 12) chk(CRdy, 1, "c_ready_high_12");
      if (i == 32) begin
        chk(ARdy, 1, "a_ready_at_32");
        chk(BRdy, 1, "b_ready_at_32");
      end
      if (i < 32) step();
    end

    for (int r = 1; r < 32; r++) begin
      bus_a.ReadRegister1 = 5'(r);
      chk(ARd1, 0, "post_sweep_zero");
      step();
    end

    // Same-cycle write/read of register 5.
    bus_a.RegWrite = 1; bus_a.WriteRegister = 5'd5; bus_a.WriteData = 32'hDEADBEEF;
    bus_a.ReadRegister1 = 5'd5; bus_a.ReadRegister2 = 5'd5;
    bus_b.RegWrite = 1; bus_b.WriteRegister = 5'd5; bus_b.WriteData = 32'hDEADBEEF;
    bus_b.ReadRegister1 = 5'd5;
    chk(ARd1, 32'hDEADBEEF, "bypass_on_rd1");
    chk(ARd2, 32'hDEADBEEF, "bypass_on_rd2");
    chk(BRd1, 32'h0, "bypass_off_old");
    step();
    bus_a.RegWrite = 0; bus_b.RegWrite = 0;
    chk(ARd1, 32'hDEADBEEF, "a_reg5_after");
    chk(BRd1, 32'hDEADBEEF, "b_reg5_after");
    step();

    // Register 0 stays zero.
    bus_a.RegWrite = 1; bus_a.WriteRegister = '0; bus_a.WriteData = 32'h1234;
    bus_a.ReadRegister1 = '0;
    chk(ARd1, 0, "zero_reg_write_cycle");
    step();
    bus_a.RegWrite = 0;
    chk(ARd1, 0, "zero_reg_after");
    step();

    // Clear plus write in the same cycle drops the write and re-sweeps.
    bus_a.RegWrite = 1; bus_a.WriteRegister = 5'd7; bus_a.WriteData = 32'hA5;
    step();
    bus_a.ReadRegister1 = 5'd7;
    bus_a.WriteRegister = 5'd9; bus_a.WriteData = 32'h55; bus_a.Clear = 1;
    chk(ARd1, 32'hA5, "reg7_written");
    bus_a.ReadRegister1 = 5'd9; bus_a.ReadRegister2 = 5'd7;
    exp_q.pop_back();
    chk(ARd1, 0, "clear_drops_bypass");
    chk(ARd2, 32'hA5, "reg7_before_clear");
    step();
    bus_a.Clear = 0; bus_a.RegWrite = 0;
    for (int i = 0; i <= 32; i++) begin
      if (i == 0 || i == 31) chk(ARdy, 0, "clear_ready_low");
      if (i == 0) chk(ARd1, 0, "clear_rd_forced_zero");
      if (i == 20) bus_a.Clear = 1;
      if (i == 21) bus_a.Clear = 0;
      if (i == 31) begin
        bus_a.RegWrite = 1; bus_a.WriteRegister = 5'd20; bus_a.WriteData = 32'h77;
      end
      if (i == 32) begin
        bus_a.RegWrite = 0;
        chk(ARdy, 1, "clear_ready_at_32");
        chk(ARd1, 0, "reg9_after_clear");
        chk(ARd2, 0, "reg7_after_clear");
      end
      if (i < 32) step();
    end
    step();
    bus_a.ReadRegister1 = 5'd20;
    chk(ARd1, 0, "write_ignored_in_sweep");
    step();

    // Narrow, non-power-of-two instance: out-of-range address.
    bus_c.RegWrite = 1; bus_c.WriteRegister = 4'd11; bus_c.WriteData = 8'h3C;
    bus_c.ReadRegister1 = 4'd11;
    chk(CRd1, 32'h3C, "c_bypass_11");
    step();
    bus_c.WriteRegister = 4'd13; bus_c.WriteData = 8'hFF;
    bus_c.ReadRegister1 = 4'd13; bus_c.ReadRegister2 = 4'd11;
    chk(CRd1, 0, "c_oob_write_cycle");
    chk(CRd2, 32'h3C, "c_reg11_write_cycle");
    step();
    bus_c.RegWrite = 0;
    chk(CRd1, 0, "c_oob_after");
    chk(CRd2, 32'h3C, "c_reg11_after");
    step();
    step();

    if (exp_q.size() != 0) begin
      errors += exp_q.size();
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
